// File: rtl/rc4_key_search_dispatcher.sv
// rc4_key_search_dispatcher
// Hands candidate RC4 keys to N_CORES independent decrypt/check cores (at most
// one dispatch per cycle, lowest free core first), collects their verdicts and
// stops the search on the first core reporting a valid decrypt.
// Optional feature macro: KEY_RANGE_EN adds key_lo/key_hi (sampled with start);
// without it the search range is fixed at 0..KEY_MAX.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              search request, honoured only in IDLE or DONE
//   key_lo, key_hi     (KEY_RANGE_EN only) inclusive search range
//   core_start/key     per-core dispatch pulse and held key slice
//   core_done/found    per-core verdict pulse and result
//   core_abort         one-cycle "drop current work" pulse to all cores
//   busy/done          searching / search finished
//   success/fail       finished with a key / finished with range exhausted
//   found_key          winning key, held through DONE
//   keys_dispatched    keys issued in the current search
module rc4_key_search_dispatcher #(
  parameter int unsigned          KEY_WIDTH = 24,
  parameter int unsigned          N_CORES   = 4,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
`ifdef KEY_RANGE_EN
  input  logic [KEY_WIDTH-1:0]         key_lo,
  input  logic [KEY_WIDTH-1:0]         key_hi,
`endif
  output logic [N_CORES-1:0]           core_start,
  output logic [N_CORES*KEY_WIDTH-1:0] core_key,
  input  logic [N_CORES-1:0]           core_done,
  input  logic [N_CORES-1:0]           core_found,
  output logic                         core_abort,
  output logic                         busy,
  output logic                         done,
  output logic                         success,
  output logic                         fail,
  output logic [KEY_WIDTH-1:0]         found_key,
  output logic [KEY_WIDTH:0]           keys_dispatched
);

  localparam int unsigned CNT_W = KEY_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     next_key;   // one bit wider so an all-ones range never wraps
  logic [N_CORES-1:0]   busy_mask;

  logic [KEY_WIDTH-1:0] range_hi;
  logic [KEY_WIDTH-1:0] start_lo_c;
  logic                 start_bad_c;

`ifdef KEY_RANGE_EN
  // Range is captured with the accepted start and held for the whole search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_hi <= '0;
    end else if (start && state != S_RUN) begin
      range_hi <= key_hi;
    end
  end

  assign start_lo_c  = key_lo;
  assign start_bad_c = key_lo > key_hi;
`else
  assign range_hi    = KEY_MAX;
  assign start_lo_c  = '0;
  assign start_bad_c = 1'b0;
`endif

  // Verdicts from cores we never dispatched to are ignored.
  logic [N_CORES-1:0]   done_ok_c;
  logic [N_CORES-1:0]   found_ok_c;
  logic [N_CORES-1:0]   disp_c;
  logic                 any_found_c;
  logic                 have_key_c;
  logic                 exhausted_c;
  logic [KEY_WIDTH-1:0] win_key_c;

  assign done_ok_c   = core_done & busy_mask;
  assign found_ok_c  = done_ok_c & core_found;
  assign any_found_c = |found_ok_c;
  assign have_key_c  = next_key <= {1'b0, range_hi};
  assign exhausted_c = !have_key_c && (busy_mask == '0);

  // Lowest-index free core gets the next key; lowest-index finder wins.
  always_comb begin
    disp_c    = '0;
    win_key_c = '0;
    for (int i = int'(N_CORES) - 1; i >= 0; i--) begin
      if (!busy_mask[i] && !core_done[i]) begin
        disp_c    = '0;
        disp_c[i] = 1'b1;
      end
      if (found_ok_c[i]) begin
        win_key_c = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
    if (state != S_RUN || any_found_c || !have_key_c) begin
      disp_c = '0;
    end
  end

  // Search FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      next_key        <= '0;
      busy_mask       <= '0;
      core_key        <= '0;
      core_start      <= '0;
      core_abort      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      success         <= 1'b0;
      fail            <= 1'b0;
      found_key       <= '0;
      keys_dispatched <= '0;
    end else begin
      core_start <= '0;
      core_abort <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            next_key        <= {1'b0, start_lo_c};
            keys_dispatched <= '0;
            busy_mask       <= '0;
            found_key       <= '0;
            success         <= 1'b0;
            if (start_bad_c) begin
              // Empty range: finish immediately without touching the cores.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              fail  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              fail  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (any_found_c) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            success    <= 1'b1;
            found_key  <= win_key_c;
            core_abort <= 1'b1;
            busy_mask  <= '0;
          end else if (exhausted_c) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            fail  <= 1'b1;
          end else begin
            busy_mask  <= (busy_mask & ~done_ok_c) | disp_c;
            core_start <= disp_c;
            if (|disp_c) begin
              next_key        <= next_key + CNT_W'(1);
              keys_dispatched <= keys_dispatched + CNT_W'(1);
            end
            for (int i = 0; i < int'(N_CORES); i++) begin
              if (disp_c[i]) begin
                core_key[i*KEY_WIDTH +: KEY_WIDTH] <= next_key[KEY_WIDTH-1:0];
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_key_search_dispatcher.sv
// tb_rc4_key_search_dispatcher
// Drives the dispatcher with behavioural cores (per-core latency, found when the
// held key matches a target) and checks dispatch order, verdict latency, abort,
// final status and counters against expectations derived from the search rules.
module tb_rc4_key_search_dispatcher;

  localparam int unsigned KW     = 24;
  localparam int unsigned NC     = 2;
  localparam int          BUDGET = 1000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [NC-1:0]   core_start;
  logic [NC*KW-1:0] core_key;
  logic [NC-1:0]   core_done;
  logic [NC-1:0]   core_found;
  logic            core_abort;
  logic            busy;
  logic            done;
  logic            success;
  logic            fail;
  logic [KW-1:0]   found_key;
  logic [KW:0]     keys_dispatched;
`ifdef KEY_RANGE_EN
  logic [KW-1:0]   key_lo;
  logic [KW-1:0]   key_hi;
`endif

  rc4_key_search_dispatcher #(
    .KEY_WIDTH (KW),
    .N_CORES   (NC),
    .KEY_MAX   (24'd15)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
`ifdef KEY_RANGE_EN
    .key_lo          (key_lo),
    .key_hi          (key_hi),
`endif
    .core_start      (core_start),
    .core_key        (core_key),
    .core_done       (core_done),
    .core_found      (core_found),
    .core_abort      (core_abort),
    .busy            (busy),
    .done            (done),
    .success         (success),
    .fail            (fail),
    .found_key       (found_key),
    .keys_dispatched (keys_dispatched)
  );

  always #5 clk = ~clk;

  // lat0/lat1: fixed core latency (0 = random 1..8 per job); tga/tgb: keys that
  // decrypt correctly (-1 = none); exp_disp -1 = only compare to observed starts.
  typedef struct {
    int lat0; int lat1; int tga; int tgb; int lo; int hi; int spur;
    int exp_succ; int exp_fk; int exp_disp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int rem[NC];
  int key_of[NC];
  int lat_cfg[NC];
  bit act[NC];
  int tgt_a, tgt_b, exp_key, nstarts, cyc, spur_at;

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  function automatic int pick_lat(input int fixed);
    return (fixed > 0) ? fixed : int'($urandom_range(8, 1));
  endfunction

  // One clock: sample outputs at the falling edge, run the core models, and
  // drive this cycle's verdict inputs.
  task automatic step(output bit fd);
    bit was_act;
    @(negedge clk);
    fd = 1'b0;
    for (int i = 0; i < int'(NC); i++) begin
      was_act       = act[i];
      core_done[i]  = 1'b0;
      core_found[i] = 1'b0;
      if (core_abort) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        rem[i]--;
        if (rem[i] == 0) begin
          act[i]        = 1'b0;
          core_done[i]  = 1'b1;
          core_found[i] = (key_of[i] == tgt_a) || (key_of[i] == tgt_b);
          fd            = fd | core_found[i];
        end
      end
      if (core_start[i]) begin
        check("start_on_idle_core", 64'(was_act), 64'd0);
        check("dispatch_key", 64'(core_key[i*KW +: KW]), 64'(exp_key));
        exp_key++;
        nstarts++;
        act[i]    = 1'b1;
        key_of[i] = int'(core_key[i*KW +: KW]);
        rem[i]    = pick_lat(lat_cfg[i]);
      end
    end
    if (cyc == spur_at && !act[1] && !core_done[1] && !core_start[1]) begin
      core_done[1]  = 1'b1;
      core_found[1] = 1'b1;
    end
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_core_start"}, 64'(core_start), 64'd0);
    check({tag, "_core_key"}, 64'(core_key), 64'd0);
    check({tag, "_core_abort"}, 64'(core_abort), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_success"}, 64'(success), 64'd0);
    check({tag, "_fail"}, 64'(fail), 64'd0);
    check({tag, "_found_key"}, 64'(found_key), 64'd0);
    check({tag, "_keys_dispatched"}, 64'(keys_dispatched), 64'd0);
  endtask

  task automatic launch(input vec_t v, output bit fd);
    tgt_a      = v.tga;
    tgt_b      = v.tgb;
    lat_cfg[0] = v.lat0;
    lat_cfg[1] = v.lat1;
    exp_key    = v.lo;
    nstarts    = 0;
    spur_at    = v.spur ? 1 : -1;
`ifdef KEY_RANGE_EN
    key_lo = KW'(v.lo);
    key_hi = KW'(v.hi);
`endif
    start = 1'b1;
    cyc   = 1;
    step(fd);
    start = 1'b0;
  endtask

  task automatic run_search(input vec_t v);
    bit fd, fd_prev, seen_found;
    launch(v, fd);
    if (v.lo > v.hi) begin
      check("badrange_done", 64'(done), 64'd1);
      check("badrange_fail", 64'(fail), 64'd1);
      check("badrange_busy", 64'(busy), 64'd0);
    end else begin
      check("run_busy", 64'(busy), 64'd1);
      check("run_done_clr", 64'(done), 64'd0);
      check("run_success_clr", 64'(success), 64'd0);
      check("run_fail_clr", 64'(fail), 64'd0);
      check("run_found_key_clr", 64'(found_key), 64'd0);
      check("run_count_clr", 64'(keys_dispatched), 64'd0);
    end
    seen_found = 1'b0;
    for (int n = 0; n < BUDGET && !done; n++) begin
      fd_prev = fd;
      step(fd);
      if (fd_prev) begin
        seen_found = 1'b1;
        check("verdict_to_done", 64'(done), 64'd1);
        check("abort_pulse", 64'(core_abort), 64'd1);
      end
      if (seen_found) check("no_start_after_found", 64'(core_start), 64'd0);
    end
    check("search_ends", 64'(done), 64'd1);
    check("final_success", 64'(success), 64'(v.exp_succ));
    check("final_fail", 64'(fail), 64'(v.exp_succ == 0));
    check("final_found_key", 64'(found_key), 64'(v.exp_fk));
    if (v.exp_disp >= 0) check("final_dispatched", 64'(keys_dispatched), 64'(v.exp_disp));
    check("dispatched_vs_starts", 64'(keys_dispatched), 64'(nstarts));
    step(fd);
    check("abort_single", 64'(core_abort), 64'd0);
    check("done_held", 64'(done), 64'd1);
    check("found_key_held", 64'(found_key), 64'(v.exp_fk));
    check("idle_no_start", 64'(core_start), 64'd0);
  endtask

  vec_t tbl[$];

  initial begin
    bit   fd;
    vec_t v;
    int   t;

    tbl.push_back('{5, 5, -1, -1,  0, 15, 0, 0,  0, 16});  // exhaust 0..15
    tbl.push_back('{5, 5,  9, -1,  0, 15, 0, 1,  9, 10});  // found 9
    tbl.push_back('{5, 4,  6,  7,  0, 15, 0, 1,  6,  8});  // simultaneous finders
    tbl.push_back('{5, 5, -1, -1,  0, 15, 1, 0,  0, 16});  // spurious verdict
    tbl.push_back('{3, 3,  0, -1,  0, 15, 0, 1,  0,  2});  // first key wins
    tbl.push_back('{1, 1, 15, -1,  0, 15, 0, 1, 15, 16});  // last key wins
`ifdef KEY_RANGE_EN
    tbl.push_back('{5, 5, -1, -1, 10, 12, 0, 0,  0,  3});
    tbl.push_back('{2, 2, 11, -1, 10, 12, 0, 1, 11,  2});
    tbl.push_back('{5, 5, -1, -1,  5,  4, 0, 0,  0,  0});
`endif

    for (int i = 0; i < int'(NC); i++) begin
      act[i] = 1'b0; rem[i] = 0; key_of[i] = -1; lat_cfg[i] = 1;
    end
    tgt_a = -1; tgt_b = -1; exp_key = 0; nstarts = 0; cyc = 0; spur_at = -1;
    rst_n      = 1'b0;
    start      = 1'b0;
    core_done  = '0;
    core_found = '0;
`ifdef KEY_RANGE_EN
    key_lo = '0;
    key_hi = '0;
`endif
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    step(fd);

    foreach (tbl[i]) run_search(tbl[i]);

    // Random latencies, random target (or none) over the full range.
    for (int r = 0; r < 20; r++) begin
      t = int'($urandom_range(23, 0));
      if (t > 15) v = '{0, 0, -1, -1, 0, 15, 0, 0, 0, 16};
      else        v = '{0, 0,  t, -1, 0, 15, 0, 1, t, -1};
      run_search(v);
    end

    // Reset in the middle of a search, then a fresh search from key 0.
    v = '{5, 5, -1, -1, 0, 15, 0, 0, 0, 16};
    launch(v, fd);
    repeat (6) step(fd);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    for (int i = 0; i < int'(NC); i++) act[i] = 1'b0;
    core_done  = '0;
    core_found = '0;
    step(fd);
    check_zero("reset_held");
    rst_n = 1'b1;
    step(fd);
    run_search(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_key_search_dispatcher.md
Name: rc4_key_search_dispatcher

Overview:
Parametrised successor to the single-pipeline key search sequencer. Distributes candidate secret keys across N_CORES independent RC4 decrypt/check cores (each one runs fill memory, shuffle, decrypt and check), collects their verdicts, and stops the search on the first correct key. Sits between the top-level start/LED/HEX logic and the array of cores.

Parameters:
KEY_WIDTH, 24, width of a secret key.
N_CORES, 4, number of parallel cracking cores (1..16).
KEY_MAX, 24'h3FFFFF, last key in the default search range (inclusive).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  search request; sampled only in IDLE or DONE
core_start  output  N_CORES  one-cycle pulse per core: begin trying core_key slice
core_key  output  N_CORES*KEY_WIDTH  key for core i in bits [i*KEY_WIDTH +: KEY_WIDTH]; held until the next dispatch to that core
core_done  input  N_CORES  one-cycle pulse from core i: verdict ready
core_found  input  N_CORES  qualified by core_done[i]; 1 = key decrypted to a valid message
core_abort  output  1  one-cycle pulse to all cores: drop current work
busy  output  1  high in RUN
done  output  1  high in DONE
success  output  1  DONE with key found
fail  output  1  DONE with range exhausted
found_key  output  KEY_WIDTH  winning key, held through DONE
keys_dispatched  output  KEY_WIDTH+1  count of keys issued in the current search

Behaviour:
- Reset: state IDLE; all outputs 0; internal next_key 0, core busy mask 0, per-core in-flight key registers 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on start=1. Next cycle: next_key=range low (0), keys_dispatched=0, busy mask=0, success/fail/done=0. found_key is cleared on entry to RUN.
- RUN dispatch: at most one dispatch per cycle. Select the lowest-index core with busy bit 0 that is not reporting core_done this cycle, provided next_key <= range high. Pulse core_start[i], drive core_key slice and in-flight reg[i] = next_key, set busy[i], next_key++, keys_dispatched++. First dispatch occurs in the first RUN cycle.
- next_key is KEY_WIDTH+1 bits wide, so it never wraps when range high = all ones.
- Completion: core_done[i] with busy[i]=1 clears busy[i] at the next edge. core_done[i] with busy[i]=0 is ignored, including its core_found.
- Found: any valid core_done[i]&core_found[i] -> next cycle: state DONE, success=1, done=1, found_key = in-flight reg of the lowest such index, core_abort pulses 1 cycle, busy mask cleared. No dispatch occurs in the found cycle.
- Exhaustion: next_key > range high, busy mask 0 and no found this cycle -> DONE, fail=1, done=1. A found and an exhaustion in the same cycle resolve as found.
- start is ignored in RUN. In DONE, start launches a new search; success/fail/done drop the cycle RUN is entered.
- Async reset mid-search returns to IDLE immediately; cores share rst_n, so no abort pulse is generated.
- Verdict latency: core_done to done is 1 cycle.

Optional Feature:
KEY_RANGE_EN: when defined, adds inputs key_lo and key_hi (KEY_WIDTH each), sampled on the start cycle as the range low/high. If key_lo > key_hi, the block goes straight to DONE with fail=1 on the cycle after start, with no dispatch. When undefined, the range is fixed at 0..KEY_MAX and those ports do not exist.

Test Plan:
- N_CORES=2, KEY_MAX=15, cores answer core_done 5 cycles after core_start, never found -> keys 0..15 each dispatched exactly once; fail=1, done=1; keys_dispatched=16; success=0.
- Same config, core answers found for key 9 -> success=1, found_key=9, core_abort one pulse, no further core_start after the found cycle.
- Cores 0 and 1 both report found in the same cycle (holding keys 6 and 7) -> found_key=6.
- Spurious core_done[1]=1, core_found[1]=1 while busy[1]=0 -> ignored; search continues.
- KEY_RANGE_EN: key_lo=10, key_hi=12 -> only keys 10, 11, 12 dispatched, then fail; key_lo=5, key_hi=4 -> fail the cycle after start with zero dispatches.
- rst_n low mid-RUN, then start again -> all outputs 0 during reset; the new search restarts at key 0 with keys_dispatched counting from 0.
